// File: rtl/decoder_seq.sv
// Registered N-to-2**N one-hot decoder with a DIRECT (decode din) mode and a
// SCAN mode that sweeps the outputs with a programmable dwell per index.
module decoder_seq #(
  parameter int N              = 2,
  parameter int DW             = 8,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      din,
  input  logic              din_valid,
  input  logic [DW-1:0]     dwell,
  output logic [2**N-1:0]   dout,
  output logic              dout_valid,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_e;

  state_e          state_q, state_d, target;
  logic [W-1:0]    oh_q, oh_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    if (!en)       target = ST_IDLE;
    else if (mode) target = ST_SCAN;
    else           target = ST_DIRECT;
  end

  // NOTE: every signal gets a default before any branch so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = target;
    oh_d    = oh_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;

    if (target != state_q) begin
      // Any state change drops the previous selection; SCAN starts at index 0.
      oh_d    = '0;
      valid_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      if (target == ST_SCAN) begin
        oh_d    = W'(1);
        valid_d = 1'b1;
        dwell_d = dwell;
      end
    end else begin
      case (state_q)
        ST_DIRECT: begin
          if (din_valid) begin
            oh_d    = W'(1) << din;
            idx_d   = din;
            valid_d = 1'b1;
          end
        end
        ST_SCAN: begin
          if (cnt_q == dwell_q) begin
            idx_d   = idx_q + N'(1);
            oh_d    = {oh_q[W-2:0], oh_q[W-1]};
            cnt_d   = '0;
            dwell_d = dwell;
            wrap_d  = (idx_q == {N{1'b1}});
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      oh_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout       = OUT_ACTIVE_LOW ? ~oh_q : oh_q;
  assign dout_valid = valid_q;
  assign idx        = idx_q;
  assign wrap       = wrap_q;

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor to the team's fixed 2-to-4 combinational decoder.
- Two modes:
  - DIRECT: decodes a sampled input code.
  - SCAN: sweeps the outputs in sequence with a programmable dwell, for digit/row strobing and select-line sequencing.
- Sits between control logic and multiplexed output drivers (display digit enables, bank selects).

Parameters:
- N, 2, input code width; output width is 2**N (N from 1 to 6).
- DW, 8, dwell counter width.
- OUT_ACTIVE_LOW, 0, when 1 the physical dout is inverted (active level 0, inactive level 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; 0 forces all outputs inactive
- mode  in  1  0 = DIRECT, 1 = SCAN
- din  in  N  code to decode (DIRECT)
- din_valid  in  1  din qualifier (DIRECT)
- dwell  in  DW  cycles per scan index, minus 1
- dout  out  2**N  registered one-hot select, polarity per OUT_ACTIVE_LOW
- dout_valid  out  1  1 when dout carries an active selection
- idx  out  N  currently selected index
- wrap  out  1  one-cycle pulse on scan wrap from index 2**N-1 to 0

Behaviour:
- All outputs are registered. Internal one-hot register oh. dout = OUT_ACTIVE_LOW ? ~oh : oh.
- Reset (rst_n=0, asynchronous):
  - oh=0, so dout is at the inactive level.
  - dout_valid=0, idx=0, wrap=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: entered when en=0.
  - DIRECT: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
  - The state is re-evaluated every clock from en and mode.
- Entering any state from a different state:
  - oh=0, dout_valid=0, idx=0, counter=0, wrap=0 on that edge.
  - No selection carries across a mode change.
- IDLE: outputs are held at the reset values; din_valid is ignored.
- DIRECT:
  - On an edge with din_valid=1: oh = 1<<din, idx=din, dout_valid=1. Latency is 1 cycle (visible after the sampling edge).
  - Otherwise the last decode is held. dout_valid stays 1 once set, until the block leaves DIRECT.
  - dwell is ignored. wrap=0.
- SCAN:
  - On the entry edge: oh=1 (index 0), dout_valid=1, idx=0. dwell is latched into dwell_q and the counter is cleared.
  - Each following edge: if counter==dwell_q, then idx=idx+1 (mod 2**N), oh rotates left by one, counter=0, and dwell is re-latched. Otherwise counter=counter+1.
  - Each index is therefore held for dwell_q+1 cycles. dwell=0 advances every cycle.
  - A change of dwell mid-index takes effect only at the next index boundary.
  - wrap=1 for exactly the cycle after the edge that moves idx from 2**N-1 to 0; otherwise wrap=0.
  - din and din_valid are ignored.
- Invariant: oh is always zero or exactly one-hot; never multi-hot.
- Reset asserted mid-scan or mid-decode: all outputs go to reset values immediately (asynchronously). The first active edge after release follows the entry rules.
- en deasserted for one cycle, then reasserted: the block re-enters from index 0 (or from an empty DIRECT selection).

Test Plan:
- Reset, defaults (N=2, OUT_ACTIVE_LOW=0): rst_n=0 mid-operation -> dout=4'b0000, dout_valid=0, idx=0 without waiting for a clock edge.
- DIRECT decode: en=1, mode=0; apply din 0,1,2,3 with din_valid=1 on successive edges -> dout 0001,0010,0100,1000 each one cycle later. Then din=1 with din_valid=0 -> dout holds 1000.
- SCAN, dwell=0, N=3: dout steps 0x01,0x02,...,0x80, then back to 0x01. wrap=1 only in the cycle dout returns to 0x01; repeat over 3 sweeps.
- SCAN, dwell=2: each index is held exactly 3 cycles. Change dwell to 0 in the 2nd cycle of index 1 -> index 1 still lasts 3 cycles, index 2 onward lasts 1 cycle.
- Mode/enable switching: SCAN at idx=2, switch mode=0 -> next cycle dout=0, dout_valid=0 until the first din_valid. Pulse en=0 for one cycle in SCAN -> restart at idx=0.
- Polarity: OUT_ACTIVE_LOW=1, N=2 -> reset dout=4'b1111, din=2 decodes to 4'b1011. A random DIRECT/SCAN sequence never shows more than one active bit.
